uart_tx_arbiter: RTL and testbench

- Shares one UART transmitter among NUM_REQ byte producers, for example a debug console, CPU MMIO writes and a trace unit.
- Picks requesters round-robin and latches the chosen byte.
- Issues a single-cycle start pulse to the transmitter, then tracks its busy flag until the frame completes.
- Sits between the producers and the transmitter and is the only driver of the transmitter's data/start inputs.

---
 rtl/uart_arb_pkg.sv | 21 ++
 rtl/uart_rr_picker.sv | 37 +++
 rtl/uart_tx_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   BYTE_W      width of one transmitted byte
//   TAG_BASE    upper bits of the source tag byte (low bits carry the requester index)
//   arb_state_t arbiter FSM states; the TAG_* states are only reached when the
//               design is built with UART_ARB_TAG_EN defined.
package uart_arb_pkg;

  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] TAG_BASE = 8'hA0;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    TAG_ISSUE,
    TAG_WAIT_BUSY,
    TAG_WAIT_DONE
  } arb_state_t;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin picker.
// Searches req starting one past rr_last and wrapping at NUM_REQ; returns the
// first set position.
//   req      in  NUM_REQ  request vector
//   rr_last  in  IDX_W    index of the most recent winner
//   winner   out IDX_W    index of the selected request (0 when none found)
//   found    out 1        at least one request bit is set
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_last,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  logic [IDX_W-1:0] idx;

  // Offsets 1..NUM_REQ visit every index once, ending on rr_last itself so
  // the previous winner has lowest priority.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = IDX_W'((int'(rr_last) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// A winner's byte is latched, a one-cycle tx_ok start pulse is issued together
// with the winner's req_ready, and the transmitter's tx_busy is then tracked
// until the frame ends. If tx_busy does not rise within BUSY_TIMEOUT cycles of
// the start pulse the byte is dropped and timeout_err pulses.
//
// Optional build macro UART_ARB_TAG_EN: whenever the winner differs from the
// last requester whose byte completed (or on the first grant after reset), a
// tag byte TAG_BASE | grant_id is sent ahead of the data byte.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   req_valid    in   NUM_REQ    per-requester byte valid
//   req_data     in   NUM_REQ*8  packed bytes, requester i at [8i+7:8i]
//   req_ready    out  NUM_REQ    one-cycle accept pulse
//   tx_data      out  8          byte to the transmitter
//   tx_ok        out  1          start pulse to the transmitter
//   tx_busy      in   1          transmitter busy
//   grant_id     out  clog2(NUM_REQ) requester being served
//   active       out  1          arbiter not idle
//   timeout_err  out  1          pulse when tx_busy failed to rise in time
//
// Legal ranges: NUM_REQ 2..8, BUSY_TIMEOUT >= 2.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*BYTE_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        tx_ok,
  input  logic                        tx_busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        active,
  output logic                        timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT);
  // The counter starts at 0 in the first wait cycle; firing the registered
  // timeout when it holds BUSY_TIMEOUT-2 makes timeout_err appear exactly
  // BUSY_TIMEOUT cycles after the start pulse.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 2);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_last;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   win;
  logic               found;
  logic [NUM_REQ-1:0] win_onehot;
  logic [BYTE_W-1:0]  req_bytes [NUM_REQ];

`ifdef UART_ARB_TAG_EN
  logic [BYTE_W-1:0]  hold_q;     // data byte parked while the tag is on the line
  logic [IDX_W-1:0]   last_sent;
  logic               last_vld;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req_valid),
    .rr_last (rr_last),
    .winner  (win),
    .found   (found)
  );

  assign win_onehot = NUM_REQ'(1) << win;

  // Single FSM; every output is a register updated with the state. Without
  // the tag feature tx_data itself serves as the hold register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_last     <= IDX_W'(NUM_REQ - 1);
      cnt         <= '0;
      tx_data     <= '0;
      tx_ok       <= 1'b0;
      req_ready   <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
`ifdef UART_ARB_TAG_EN
      hold_q      <= '0;
      last_sent   <= '0;
      last_vld    <= 1'b0;
`endif
    end else begin
      tx_ok       <= 1'b0;
      req_ready   <= '0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant_id <= win;
            rr_last  <= win;
            tx_ok    <= 1'b1;
            active   <= 1'b1;
`ifdef UART_ARB_TAG_EN
            hold_q   <= req_bytes[win];
            if (!last_vld || (win != last_sent)) begin
              tx_data <= TAG_BASE | BYTE_W'(win);
              state   <= TAG_ISSUE;
            end else begin
              tx_data   <= req_bytes[win];
              req_ready <= win_onehot;
              state     <= ISSUE;
            end
`else
            tx_data   <= req_bytes[win];
            req_ready <= win_onehot;
            state     <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            active <= 1'b0;
            state  <= IDLE;
`ifdef UART_ARB_TAG_EN
            last_sent <= grant_id;
            last_vld  <= 1'b1;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG_ISSUE: begin
          cnt   <= '0;
          state <= TAG_WAIT_BUSY;
        end
        TAG_WAIT_BUSY: begin
          // A tag timeout abandons the data byte too and leaves last_sent alone.
          if (tx_busy) begin
            state <= TAG_WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            active      <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        TAG_WAIT_DONE: begin
          if (!tx_busy) begin
            tx_data   <= hold_q;
            tx_ok     <= 1'b1;
            req_ready <= NUM_REQ'(1) << grant_id;
            state     <= ISSUE;
          end
        end
`endif
        default: begin
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a directed vector table of grants
// driven through a simple transmitter model, plus hand-written sequences for
// the busy timeout and an asynchronous reset in the middle of a frame.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 16;
  localparam int BIT_CLKS     = 8;
  localparam int WAIT_LIMIT   = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_ok;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  bit         tx_en = 1'b1;
  int         tx_cnt = 0;
  logic [7:0] line_byte = '0;

`ifdef UART_ARB_TAG_EN
  int m_last = 0;
  bit m_last_vld = 1'b0;
`endif

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_ok       (tx_ok),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter model: a start pulse seen in one cycle raises busy just after
  // the following edge and holds it for a 10-bit frame.
  initial begin
    logic       ok_s;
    logic [7:0] d_s;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      ok_s = tx_ok;
      d_s  = tx_data;
      @(posedge clk);
      #1;
      if (!reset) begin
        tx_busy = 1'b0;
        tx_cnt  = 0;
      end else if (tx_cnt != 0) begin
        tx_cnt = tx_cnt - 1;
        if (tx_cnt == 0) tx_busy = 1'b0;
      end else if (ok_s && tx_en) begin
        tx_busy   = 1'b1;
        tx_cnt    = 10 * BIT_CLKS;
        line_byte = d_s;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rst;
    logic [3:0]  add_mask;
    logic [31:0] add_data;
    logic [3:0]  mid_mask;
    logic [31:0] mid_data;
    bit          keep;
    int          exp_id;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic add_req(input logic [3:0] m, input logic [31:0] d);
    req_data  = (req_data & ~lanes(m)) | (d & lanes(m));
    req_valid = req_valid | m;
  endtask

  task automatic wait_tx_ok(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < WAIT_LIMIT; c++) begin
      @(negedge clk);
      if (tx_ok) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < WAIT_LIMIT; c++) begin
      @(negedge clk);
      if (tx_busy === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
`ifdef UART_ARB_TAG_EN
    m_last_vld = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // One transmitted byte: start pulse contents, single-cycle tx_ok, byte on
  // the line, tx_data held through busy, and active dropping after the frame.
  task automatic run_frame(input string nm, input logic [7:0] eb, input logic [3:0] er,
                           input int eid, input bit data_frame, input logic [3:0] drop,
                           input logic [3:0] mm, input logic [31:0] md);
    bit ok;
    wait_tx_ok(ok);
    check({nm, "_tx_ok_seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    check({nm, "_tx_data"}, 32'(tx_data), 32'(eb));
    check({nm, "_req_ready"}, 32'(req_ready), 32'(er));
    check({nm, "_grant_id"}, 32'(grant_id), 32'(eid));
    check({nm, "_active"}, 32'(active), 32'd1);
    @(posedge clk);
    #1;
    req_valid = req_valid & ~drop;
    add_req(mm, md);
    @(negedge clk);
    check({nm, "_tx_ok_single"}, 32'(tx_ok), 32'd0);
    wait_busy(1'b1, ok);
    check({nm, "_busy_rise"}, 32'(ok), 32'd1);
    check({nm, "_line_byte"}, 32'(line_byte), 32'(eb));
    wait_busy(1'b0, ok);
    check({nm, "_busy_fall"}, 32'(ok), 32'd1);
    if (!ok) return;
    check({nm, "_tx_data_held"}, 32'(tx_data), 32'(eb));
    if (data_frame) begin
      check({nm, "_active_at_fall"}, 32'(active), 32'd1);
      @(negedge clk);
      check({nm, "_active_after"}, 32'(active), 32'd0);
    end
  endtask

  task automatic serve(input string nm, input int id, input logic [7:0] b, input bit keep,
                       input logic [3:0] mm, input logic [31:0] md);
    logic [3:0] oh;
    oh = 4'b0001 << id;
`ifdef UART_ARB_TAG_EN
    if (!m_last_vld || m_last != id)
      run_frame({nm, "_tag"}, 8'hA0 | 8'(id), 4'b0000, id, 1'b0, 4'b0000, 4'b0000, 32'h0);
`endif
    run_frame(nm, b, oh, id, 1'b1, keep ? 4'b0000 : oh, mm, md);
`ifdef UART_ARB_TAG_EN
    m_last     = id;
    m_last_vld = 1'b1;
`endif
  endtask

  initial begin
    bit   ok;
    int   first;
    int   width;
    logic act_at;

    //            rst   add      add_data       mid      mid_data       keep  id  byte
    vecs[0]  = '{1'b1, 4'b0001, 32'h0000_0035, 4'b0000, 32'h0000_0000, 1'b0, 0, 8'h35};
    vecs[1]  = '{1'b1, 4'b1111, 32'h1312_1110, 4'b0000, 32'h0000_0000, 1'b0, 0, 8'h10};
    vecs[2]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0, 1, 8'h11};
    vecs[3]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0, 2, 8'h12};
    vecs[4]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0, 3, 8'h13};
    vecs[5]  = '{1'b0, 4'b0101, 32'h0022_0020, 4'b0000, 32'h0000_0000, 1'b0, 0, 8'h20};
    vecs[6]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0, 2, 8'h22};
    vecs[7]  = '{1'b0, 4'b0010, 32'h0000_3100, 4'b1000, 32'h3300_0000, 1'b1, 1, 8'h31};
    vecs[8]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0, 3, 8'h33};
    vecs[9]  = '{1'b0, 4'b0000, 32'h0000_0000, 4'b0000, 32'h0000_0000, 1'b0, 1, 8'h31};
    vecs[10] = '{1'b1, 4'b0100, 32'h0055_0000, 4'b0000, 32'h0000_0000, 1'b0, 2, 8'h55};
    vecs[11] = '{1'b0, 4'b0100, 32'h0055_0000, 4'b0000, 32'h0000_0000, 1'b0, 2, 8'h55};
    vecs[12] = '{1'b0, 4'b0001, 32'h0000_0066, 4'b0000, 32'h0000_0000, 1'b0, 0, 8'h66};

    // Outputs while reset is held from time zero.
    @(negedge clk);
    check("rst_tx_ok", 32'(tx_ok), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rst) do_reset();
      add_req(vecs[i].add_mask, vecs[i].add_data);
      serve($sformatf("v%0d", i), vecs[i].exp_id, vecs[i].exp_byte, vecs[i].keep,
            vecs[i].mid_mask, vecs[i].mid_data);
    end

    // Busy timeout: transmitter never responds.
    do_reset();
    tx_en = 1'b0;
    add_req(4'b0001, 32'h0000_0077);
    wait_tx_ok(ok);
    check("to_tx_ok_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    first  = 0;
    width  = 0;
    act_at = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (timeout_err) begin
        width++;
        if (first == 0) begin
          first  = k;
          act_at = active;
        end
      end
    end
    check("to_latency", 32'(first), 32'(BUSY_TIMEOUT));
    check("to_width", 32'(width), 32'd1);
    check("to_idle", 32'(act_at), 32'd0);
    tx_en = 1'b1;
    add_req(4'b0011, 32'h0000_5150);
    serve("to_next1", 1, 8'h51, 1'b0, 4'b0000, 32'h0);
    serve("to_next0", 0, 8'h50, 1'b0, 4'b0000, 32'h0);

    // Asynchronous reset while a frame is on the line.
    do_reset();
    add_req(4'b0100, 32'h005A_0000);
    wait_tx_ok(ok);
    check("mr_tx_ok_seen", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_busy(1'b1, ok);
    check("mr_busy_rise", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    check("mr_pre_active", 32'(active), 32'd1);
    check("mr_pre_grant", 32'(grant_id), 32'd2);
    #2;
    reset = 1'b0;
    #1;
    check("mr_tx_data", 32'(tx_data), 32'd0);
    check("mr_grant_id", 32'(grant_id), 32'd0);
    check("mr_active", 32'(active), 32'd0);
    check("mr_tx_ok", 32'(tx_ok), 32'd0);
    check("mr_req_ready", 32'(req_ready), 32'd0);
    check("mr_timeout_err", 32'(timeout_err), 32'd0);
`ifdef UART_ARB_TAG_EN
    m_last_vld = 1'b0;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    add_req(4'b0101, 32'h0042_0041);
    serve("mr_next0", 0, 8'h41, 1'b0, 4'b0000, 32'h0);
    serve("mr_next2", 2, 8'h42, 1'b0, 4'b0000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
